switch_allocator: RTL and testbench
===================================

# switch_allocator

Packet-level switch allocator and sequencer for the 5x5 registered router crossbar. Arbitrates the five input ports competing for the five output ports with a per-output round-robin arbiter. Holds each output locked to one input from head flit to tail flit, and drives the crossbar's one-hot select lines, the per-input flit grants and a per-output valid flag aligned with the crossbar's registered outputs.

## Interface
- No parameters. Fixed: 5 ports, port index 0..4; select bit k = input k, the same one-hot encoding the crossbar decodes.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  5  req[k]: input k presents a flit this cycle
- tail  input  5  tail[k]: the flit on input k is the last of its packet (head and tail may coincide)
- dst0..dst4  input  3 each  requested output port of input k; values 5..7 are invalid
- out_ready  input  5  out_ready[j]: downstream of output j can accept a flit this cycle
- sel0..sel4  output  5 each  registered one-hot crossbar select for output j; 5'b00000 when the output is idle
- gnt  output  5  gnt[k]: the flit on input k is consumed this cycle (combinational)
- out_valid  output  5  registered; out_valid[j]=1 means crossbar output oj carries a valid flit this cycle

## Operation
- Per-output state: IDLE or LOCKED(owner 0..4); per-output round-robin pointer ptr_j (0..4).
- Input k requests output j when req[k]=1 and dst_k==j. dst_k ≥5 requests nothing and is never granted.
- IDLE output j: if any input requests j, the winner is the first requester scanning ptr_j, ptr_j+1, … mod 5 (4 wraps to 0). At the clock edge: LOCKED(winner), selj <= onehot(winner). No grant is issued in the arbitration cycle.
- LOCKED(k) output j: gnt[k] = req[k] & (dst_k==j) & out_ready[j]. selj stays onehot(k).
- Release: when gnt[k] & tail[k], at that edge output j goes IDLE, selj <= 0, ptr_j <= (k+1) mod 5.
- An input requests exactly one output, so at most one bit of gnt is driven per locked output, and no input is ever owner of two outputs.
- Requester rules:
  - Keep dst_k stable while req[k]=1 until the tail flit is granted.
  - Keep the flit on ik while req[k]=1 and gnt[k]=0.
  - req[k] may drop mid-packet. The lock is held, no grant is issued, and the owner resumes later.
- out_valid[j] <= (output j LOCKED) & gnt[owner_j], registered at the same edge at which the crossbar captures the flit.
- Simultaneous events:
  - Several inputs requesting one IDLE output: only the round-robin winner locks. The losers keep req high and are considered again once the output is IDLE.
  - Outputs arbitrate independently in the same cycle.
  - A tail grant and new requests in the same cycle: the release wins. Re-arbitration happens in the following cycle using the updated pointer.
- Reset (asserted at any time, including mid-packet):
  - all outputs IDLE, sel0..sel4 = 5'b00000, out_valid = 0, ptr_j = 0
  - gnt = 0 immediately, since no output is locked
  - packets in flight are dropped; sources re-send from the head flit.

## Timing
- Head flit request at cycle N:
  - lock and selj valid at cycle N+1
  - gnt[k]=1 in N+1 if out_ready[j]
  - crossbar captures the flit at the end of N+1
  - oj and out_valid[j]=1 in cycle N+2
- Body flits: one per cycle while req and out_ready are high, each appearing with out_valid exactly one cycle after its gnt.
- out_ready[j]=0: gnt withheld, out_valid[j]=0 in the next cycle, lock retained.
- Tail granted at cycle M: output IDLE in M+1 (arbitration), the new owner is granted at the earliest in M+2. This gives one bubble cycle per packet turnaround on a contended output.
- Single-flit packet (head=tail): lock at N+1, grant and release at N+1, IDLE at N+2.

## Test plan
- Reset values:
  - Stimulus: assert rst asynchronously mid-cycle while output 2 is locked to input 1.
  - Required: sel2=00000, out_valid=00000 and gnt=00000 without waiting for a clock edge. After rst drops, input 1 re-requests dst=2 and sel2=00010 one cycle later.
- Uncontended packet:
  - Stimulus: input 0, dst=3, 3 flits 0xA1,0xA2,0xA3, tail on the third, out_ready=11111.
  - Required: sel3=00001 from N+1; gnt[0]=1 in N+1..N+3; o3 shows A1,A2,A3 with out_valid[3]=1 in N+2..N+4; sel3=00000 at N+4.
- Round-robin contention:
  - Stimulus: inputs 1, 2 and 4 all request dst=0 continuously with single-flit packets, ptr_0=0.
  - Required: grant order 1, 2, 4, 1, …, with each grant separated by one idle cycle.
- Back-pressure:
  - Stimulus: out_ready[1]=0 for 3 cycles in the middle of a 4-flit packet from input 3.
  - Required: gnt[3]=0 and out_valid[1]=0 one cycle later for those cycles; sel1 stays 01000; no flit lost or duplicated.
- Parallel and invalid requests:
  - Stimulus: input 0→dst 1, input 1→dst 0 and input 2→dst 6, all in the same cycle.
  - Required: sel1=00001 and sel0=00010 locked simultaneously; gnt[2] is never asserted.
- Tail and new request in the same cycle:
  - Stimulus: input 4 sends its tail to dst 2 while input 3 requests dst 2.
  - Required: sel2=00000 for one cycle, then sel2=01000; ptr_2 wraps to 0.

Source files
------------

// File: rtl/switch_allocator.sv
// Packet-level 5x5 switch allocator: per-output round-robin arbitration,
// head-to-tail output locking, one-hot crossbar selects and aligned valid flags.
module switch_allocator (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic [2:0] dst0,
    input  logic [2:0] dst1,
    input  logic [2:0] dst2,
    input  logic [2:0] dst3,
    input  logic [2:0] dst4,
    input  logic [4:0] out_ready,
    output logic [4:0] sel0,
    output logic [4:0] sel1,
    output logic [4:0] sel2,
    output logic [4:0] sel3,
    output logic [4:0] sel4,
    output logic [4:0] gnt,
    output logic [4:0] out_valid
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t     r_state [5];
    logic [2:0] r_owner [5];
    logic [2:0] r_ptr   [5];
    logic [4:0] r_sel   [5];
    logic [4:0] r_out_valid;

    logic [2:0] w_dst     [5];
    logic [4:0] w_req_for [5];
    logic [2:0] w_pick    [5];
    logic [4:0] w_out_gnt;
    logic [4:0] w_release;
    logic [4:0] w_gnt;

    // First requester found scanning from ptr upward, wrapping 4 -> 0.
    function automatic logic [2:0] rr_pick(input logic [4:0] reqs, input logic [2:0] ptr);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= 5) idx = idx - 5;
            if (!found && reqs[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_dst[0] = dst0;
    assign w_dst[1] = dst1;
    assign w_dst[2] = dst2;
    assign w_dst[3] = dst3;
    assign w_dst[4] = dst4;

    // Invalid destinations (5..7) never match an output and so request nothing.
    always_comb begin
        for (int unsigned j = 0; j < 5; j++) begin
            w_req_for[j] = '0;
            for (int unsigned k = 0; k < 5; k++) begin
                w_req_for[j][k] = req[k] && (w_dst[k] == 3'(j));
            end
            w_pick[j] = rr_pick(w_req_for[j], r_ptr[j]);
        end
    end

    always_comb begin
        w_out_gnt = '0;
        w_release = '0;
        w_gnt     = '0;
        for (int unsigned j = 0; j < 5; j++) begin
            if (r_state[j] == S_LOCKED && w_req_for[j][r_owner[j]] && out_ready[j]) begin
                w_out_gnt[j]          = 1'b1;
                w_gnt[r_owner[j]]     = 1'b1;
                w_release[j]          = tail[r_owner[j]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < 5; j++) begin
                r_state[j] <= S_IDLE;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
                r_sel[j]   <= '0;
            end
            r_out_valid <= '0;
        end else begin
            for (int unsigned j = 0; j < 5; j++) begin
                r_out_valid[j] <= w_out_gnt[j];
                case (r_state[j])
                    S_IDLE: begin
                        if (|w_req_for[j]) begin
                            r_state[j] <= S_LOCKED;
                            r_owner[j] <= w_pick[j];
                            r_sel[j]   <= 5'(1) << w_pick[j];
                        end
                    end
                    S_LOCKED: begin
                        if (w_release[j]) begin
                            r_state[j] <= S_IDLE;
                            r_sel[j]   <= '0;
                            r_ptr[j]   <= (r_owner[j] == 3'd4) ? 3'd0 : r_owner[j] + 3'd1;
                        end
                    end
                    default: begin
                        r_state[j] <= S_IDLE;
                        r_sel[j]   <= '0;
                    end
                endcase
            end
        end
    end

    assign sel0      = r_sel[0];
    assign sel1      = r_sel[1];
    assign sel2      = r_sel[2];
    assign sel3      = r_sel[3];
    assign sel4      = r_sel[4];
    assign gnt       = w_gnt;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a behavioural registered crossbar plus
// per-output scoreboard queues of expected flits, checked wherever out_valid is set.
module tb_switch_allocator;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic [2:0] dst [5];
    logic [4:0] out_ready;
    logic [4:0] sel0, sel1, sel2, sel3, sel4;
    logic [4:0] gnt;
    logic [4:0] out_valid;

    logic [4:0] sel_a [5];
    logic [7:0] flit  [5];
    logic [7:0] xo    [5];
    logic [7:0] exp_q [5][$];
    logic [7:0] chk_e;

    int tests = 0;
    int fails = 0;

    switch_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .dst0      (dst[0]),
        .dst1      (dst[1]),
        .dst2      (dst[2]),
        .dst3      (dst[3]),
        .dst4      (dst[4]),
        .out_ready (out_ready),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .gnt       (gnt),
        .out_valid (out_valid)
    );

    assign sel_a[0] = sel0;
    assign sel_a[1] = sel1;
    assign sel_a[2] = sel2;
    assign sel_a[3] = sel3;
    assign sel_a[4] = sel4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered crossbar driven by the DUT's selects.
    always @(posedge clk) begin
        for (int j = 0; j < 5; j++) begin
            logic [7:0] v;
            v = '0;
            for (int k = 0; k < 5; k++) if (sel_a[j][k]) v = v | flit[k];
            xo[j] <= v;
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 5; j++) begin
            if (out_valid[j]) begin
                tests++;
                if (exp_q[j].size() == 0) begin
                    fails++;
                    $error("FAIL ov%0d_unexpected observed=%0h expected=none", j, xo[j]);
                end else begin
                    chk_e = exp_q[j].pop_front();
                    assert (xo[j] === chk_e) else begin
                        fails++;
                        $error("FAIL ov%0d_flit observed=%0h expected=%0h", j, xo[j], chk_e);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    logic [4:0] rr_g  [8];
    logic [7:0] bp_f  [9];
    logic       bp_t  [9];
    logic       bp_r  [9];
    logic       bp_q  [9];
    logic [4:0] bp_g  [9];
    logic [4:0] bp_ov [9];
    logic [4:0] bp_s  [9];

    initial begin
        rst       = 1'b1;
        req       = 5'b11111;
        tail      = '0;
        out_ready = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            dst[k]  = 3'd0;
            flit[k] = '0;
        end

        // Reset state, with requests present
        at_sample();
        chk("rst_sel", {sel0, sel1, sel2, sel3, sel4}, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_gnt", gnt, 0);
        next_cycle();
        rst = 1'b0;
        req = '0;
        at_sample();

        // Uncontended 3-flit packet: input 0 -> output 3
        next_cycle();
        req = 5'b00001; dst[0] = 3'd3; flit[0] = 8'hA1; tail = '0;
        exp_q[3].push_back(8'hA1); exp_q[3].push_back(8'hA2); exp_q[3].push_back(8'hA3);
        at_sample();
        chk("u_n_sel3", sel3, 0);
        chk("u_n_gnt", gnt, 0);
        next_cycle(); at_sample();
        chk("u_n1_sel3", sel3, 5'b00001);
        chk("u_n1_gnt", gnt, 5'b00001);
        chk("u_n1_ov", out_valid, 0);
        next_cycle(); flit[0] = 8'hA2; at_sample();
        chk("u_n2_gnt", gnt, 5'b00001);
        chk("u_n2_ov", out_valid, 5'b01000);
        next_cycle(); flit[0] = 8'hA3; tail = 5'b00001; at_sample();
        chk("u_n3_gnt", gnt, 5'b00001);
        chk("u_n3_ov", out_valid, 5'b01000);
        next_cycle(); req = '0; tail = '0; at_sample();
        chk("u_n4_sel3", sel3, 0);
        chk("u_n4_ov", out_valid, 5'b01000);
        chk("u_n4_gnt", gnt, 0);
        next_cycle(); at_sample();
        chk("u_n5_ov", out_valid, 0);

        // Round-robin on output 0 among inputs 1, 2, 4 (single-flit packets)
        rr_g = '{5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000, 5'b10000, 5'b00000, 5'b00010};
        next_cycle();
        req = 5'b10110; tail = 5'b10110;
        dst[1] = 3'd0; dst[2] = 3'd0; dst[4] = 3'd0;
        flit[1] = 8'h11; flit[2] = 8'h12; flit[4] = 8'h14;
        exp_q[0].push_back(8'h11); exp_q[0].push_back(8'h12);
        exp_q[0].push_back(8'h14); exp_q[0].push_back(8'h11);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            at_sample();
            chk($sformatf("rr_c%0d_gnt", i), gnt, rr_g[i]);
            chk($sformatf("rr_c%0d_sel0", i), sel0, rr_g[i]);
        end
        next_cycle(); req = '0; tail = '0; at_sample();
        chk("rr_c8_gnt", gnt, 0);

        // Back-pressure on output 1 during a 4-flit packet from input 3
        bp_f  = '{8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hB4, 8'hB4};
        bp_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_r  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_q  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bp_g  = '{5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b00000};
        bp_ov = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00010};
        bp_s  = '{5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
        dst[3] = 3'd1;
        exp_q[1].push_back(8'hB1); exp_q[1].push_back(8'hB2);
        exp_q[1].push_back(8'hB3); exp_q[1].push_back(8'hB4);
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            req[3] = bp_q[i]; tail[3] = bp_t[i]; flit[3] = bp_f[i]; out_ready[1] = bp_r[i];
            at_sample();
            chk($sformatf("bp_c%0d_gnt", i), gnt, bp_g[i]);
            chk($sformatf("bp_c%0d_ov", i), out_valid, bp_ov[i]);
            chk($sformatf("bp_c%0d_sel1", i), sel1, bp_s[i]);
        end
        out_ready = 5'b11111; tail = '0;

        // Parallel locks plus an invalid destination
        next_cycle();
        req = 5'b00111; tail = 5'b00111;
        dst[0] = 3'd1; dst[1] = 3'd0; dst[2] = 3'd6;
        flit[0] = 8'h20; flit[1] = 8'h21; flit[2] = 8'h22;
        exp_q[1].push_back(8'h20); exp_q[0].push_back(8'h21);
        at_sample();
        chk("par_c0_gnt", gnt, 0);
        next_cycle(); at_sample();
        chk("par_c1_sel1", sel1, 5'b00001);
        chk("par_c1_sel0", sel0, 5'b00010);
        chk("par_c1_gnt", gnt, 5'b00011);
        next_cycle(); req = 5'b00100; at_sample();
        chk("par_c2_gnt", gnt, 0);
        chk("par_c2_sel", {sel0, sel1}, 0);
        chk("par_c2_ov", out_valid, 5'b00011);
        next_cycle(); at_sample();
        chk("par_c3_gnt", gnt, 0);
        chk("par_c3_sel", {sel0, sel1, sel2, sel3, sel4}, 0);
        chk("par_c3_ov", out_valid, 0);
        next_cycle(); req = '0; tail = '0; at_sample();

        // Tail of input 4 on output 2 coincides with a new request from input 3
        next_cycle();
        req = 5'b10000; dst[4] = 3'd2; flit[4] = 8'hC1; tail = '0;
        exp_q[2].push_back(8'hC1); exp_q[2].push_back(8'hC2); exp_q[2].push_back(8'hD1);
        at_sample();
        chk("tn_c0_sel2", sel2, 0);
        next_cycle(); at_sample();
        chk("tn_c1_sel2", sel2, 5'b10000);
        chk("tn_c1_gnt", gnt, 5'b10000);
        next_cycle();
        flit[4] = 8'hC2; tail = 5'b11000; req = 5'b11000; dst[3] = 3'd2; flit[3] = 8'hD1;
        at_sample();
        chk("tn_c2_gnt", gnt, 5'b10000);
        chk("tn_c2_sel2", sel2, 5'b10000);
        next_cycle(); req = 5'b01000; tail = 5'b01000; at_sample();
        chk("tn_c3_sel2", sel2, 0);
        chk("tn_c3_gnt", gnt, 0);
        next_cycle(); at_sample();
        chk("tn_c4_sel2", sel2, 5'b01000);
        chk("tn_c4_gnt", gnt, 5'b01000);
        next_cycle(); req = '0; tail = '0; at_sample();
        chk("tn_c5_sel2", sel2, 0);

        // Asynchronous reset while output 2 is locked to input 1
        next_cycle();
        req = 5'b00010; dst[1] = 3'd2; flit[1] = 8'hE1; tail = '0;
        exp_q[2].push_back(8'hE1);
        at_sample();
        chk("ar_c0_sel2", sel2, 0);
        next_cycle(); at_sample();
        chk("ar_c1_sel2", sel2, 5'b00010);
        chk("ar_c1_gnt", gnt, 5'b00010);
        next_cycle(); flit[1] = 8'hE2; at_sample();
        chk("ar_c2_sel2", sel2, 5'b00010);
        chk("ar_c2_ov", out_valid, 5'b00100);
        #1 rst = 1'b1;
        #1;
        chk("ar_async_sel", {sel0, sel1, sel2, sel3, sel4}, 0);
        chk("ar_async_ov", out_valid, 0);
        chk("ar_async_gnt", gnt, 0);
        next_cycle();
        rst = 1'b0; req = 5'b00010; flit[1] = 8'hE1; tail = 5'b00010;
        exp_q[2].push_back(8'hE1);
        at_sample();
        chk("ar_r0_sel2", sel2, 0);
        chk("ar_r0_gnt", gnt, 0);
        next_cycle(); at_sample();
        chk("ar_r1_sel2", sel2, 5'b00010);
        chk("ar_r1_gnt", gnt, 5'b00010);
        next_cycle(); req = '0; tail = '0; at_sample();
        chk("ar_r2_ov", out_valid, 5'b00100);
        chk("ar_r2_sel2", sel2, 0);

        repeat (3) next_cycle();
        at_sample();
        for (int j = 0; j < 5; j++) chk($sformatf("drain_q%0d", j), exp_q[j].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
